// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// Optional drop counter: REGFILE_ARB_DROP_COUNT_EN.
package regfile_arb_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } arb_state_t;

  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requesters plus register-file write port.
// Master drives requests; slave is the arbiter.
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int NRequesters   = 2,
  parameter int RegisterWidth = 32,
  parameter int NRegisters    = 32,
  parameter int AddrWidth     = addr_width(NRegisters)
);

  logic [NRequesters-1:0] reqValid;
  logic [NRequesters-1:0] reqReady;
  logic [NRequesters-1:0][AddrWidth-1:0] reqAddr;
  logic signed [NRequesters-1:0][RegisterWidth-1:0] reqData;

  logic wEn;
  logic [AddrWidth-1:0] wAddr;
  logic signed [RegisterWidth-1:0] wData;

  modport master (
    output reqValid, reqAddr, reqData,
    input  reqReady, wEn, wAddr, wData
  );

  modport slave (
    input  reqValid, reqAddr, reqData,
    output reqReady, wEn, wAddr, wData
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick starting at ptr.
// Emits a one-hot grant and its index.
module rr_arbiter #(
  parameter int NRequesters = 2,
  localparam int IW = (NRequesters > 1) ? $clog2(NRequesters) : 1
) (
  input  logic [NRequesters-1:0] req,
  input  logic [IW-1:0]          ptr,
  input  logic                   en,
  output logic [NRequesters-1:0] grant,
  output logic [IW-1:0]          idx
);

  logic          found;
  logic [IW-1:0] c;

  // search ptr, ptr+1, ... and take the first request
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int k = 0; k < NRequesters; k++) begin
      c = IW'((int'(ptr) + k) % NRequesters);
      if (en && !found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port.
// Zeroes x1..xN-1 after reset/clearReq. Option: REGFILE_ARB_DROP_COUNT_EN.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NRequesters   = 2,
  parameter int RegisterWidth = 32,
  parameter int NRegisters    = 32,
  parameter int AddrWidth     = addr_width(NRegisters),
  localparam int IW = (NRequesters > 1) ? $clog2(NRequesters) : 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic clearReq,
  output logic clearBusy,
  regfile_write_arbiter_if.slave bus
`ifdef REGFILE_ARB_DROP_COUNT_EN
  ,
  output logic [15:0] dropCount
`endif
);

  arb_state_t state;

  logic [AddrWidth-1:0] clearPtr;
  logic [IW-1:0] rrPtr;

  logic [NRequesters-1:0] grant;
  logic [IW-1:0] gIdx;
  logic anyGrant;
  logic grantEn;
  logic legal;
  logic [AddrWidth-1:0] gAddr;
  logic signed [RegisterWidth-1:0] gData;

  localparam logic [AddrWidth-1:0] LastAddr =
    AddrWidth'(NRegisters - 1);

  // a pending clearReq blocks the grant in its own cycle
  assign grantEn = (state == RUN) && !clearReq;

  rr_arbiter #(
    .NRequesters(NRequesters)
  ) u_rr (
    .req  (bus.reqValid),
    .ptr  (rrPtr),
    .en   (grantEn),
    .grant(grant),
    .idx  (gIdx)
  );

  assign bus.reqReady = grant;
  assign anyGrant     = |grant;
  assign gAddr        = bus.reqAddr[gIdx];
  assign gData        = bus.reqData[gIdx];
  assign legal        = (gAddr != '0) &&
                        (32'(gAddr) < 32'(NRegisters));
  assign clearBusy    = (state == CLEAR);

  // clear sequencer, rotation pointer and write-port registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= CLEAR;
      clearPtr  <= AddrWidth'(1);
      rrPtr     <= '0;
      bus.wEn   <= 1'b0;
      bus.wAddr <= '0;
      bus.wData <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          bus.wEn   <= 1'b1;
          bus.wAddr <= clearPtr;
          bus.wData <= '0;
          clearPtr  <= clearPtr + AddrWidth'(1);
          if (clearPtr == LastAddr) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (clearReq) begin
            state    <= CLEAR;
            clearPtr <= AddrWidth'(1);
            bus.wEn  <= 1'b0;
          end else if (anyGrant) begin
            rrPtr     <= IW'((int'(gIdx) + 1) % NRequesters);
            bus.wEn   <= legal;
            bus.wAddr <= gAddr;
            bus.wData <= gData;
          end else begin
            bus.wEn <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

`ifdef REGFILE_ARB_DROP_COUNT_EN
  // saturating count of accepted writes to x0 or out of range
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dropCount <= '0;
    end else if (state == RUN && clearReq) begin
      dropCount <= '0;
    end else if (anyGrant && !legal &&
                 dropCount != 16'hFFFF) begin
      dropCount <= dropCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
// Uses AddrWidth=6 so out-of-range addresses can be driven.
module tb_regfile_write_arbiter;

  logic clk;
  logic resetN;
  logic clearReq;
  logic clearBusy;
`ifdef REGFILE_ARB_DROP_COUNT_EN
  logic [15:0] dropCount;
`endif

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter_if #(
    .NRequesters  (2),
    .RegisterWidth(32),
    .NRegisters   (32),
    .AddrWidth    (6)
  ) bus ();

  regfile_write_arbiter #(
    .NRequesters  (2),
    .RegisterWidth(32),
    .NRegisters   (32),
    .AddrWidth    (6)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .clearReq (clearReq),
    .clearBusy(clearBusy),
    .bus      (bus)
`ifdef REGFILE_ARB_DROP_COUNT_EN
    ,
    .dropCount(dropCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN       = 1'b0;
    clearReq     = 1'b0;
    bus.reqValid = 2'b00;
    bus.reqAddr  = '0;
    bus.reqData  = '0;
    #1;
    check("rst_wEn", 64'(bus.wEn), 64'(0));
    check("rst_wAddr", 64'(bus.wAddr), 64'(0));
    check("rst_wData", 64'($unsigned(bus.wData)), 64'(0));
    check("rst_ready", 64'(bus.reqReady), 64'(0));
    check("rst_busy", 64'(clearBusy), 64'(1));

    // clear pass after reset, requests pending the whole time
    bus.reqValid   = 2'b11;
    bus.reqAddr[0] = 6'd2;
    bus.reqAddr[1] = 6'd4;
    @(negedge clk);
    resetN = 1'b1;
    check("pass_ready0", 64'(bus.reqReady), 64'(0));
    for (int i = 1; i <= 31; i++) begin
      tick();
      check("pass_wEn", 64'(bus.wEn), 64'(1));
      check("pass_wAddr", 64'(bus.wAddr), 64'(i));
      check("pass_wData", 64'($unsigned(bus.wData)), 64'(0));
      if (i < 31) begin
        check("pass_ready", 64'(bus.reqReady), 64'(0));
        check("pass_busy", 64'(clearBusy), 64'(1));
      end else begin
        check("pass_busy_end", 64'(clearBusy), 64'(0));
      end
    end

    // single requester: addr 5, data -7
    bus.reqValid   = 2'b01;
    bus.reqAddr[0] = 6'd5;
    bus.reqData[0] = 32'hFFFFFFF9;
    #1;
    check("single_ready", 64'(bus.reqReady), 64'(1));
    tick();
    bus.reqValid = 2'b00;
    check("single_wEn", 64'(bus.wEn), 64'(1));
    check("single_wAddr", 64'(bus.wAddr), 64'(5));
    check("single_wData", 64'($unsigned(bus.wData)),
          64'(32'hFFFFFFF9));
    #1;
    check("single_idle_ready", 64'(bus.reqReady), 64'(0));
    tick();
    check("single_wEn_off", 64'(bus.wEn), 64'(0));

    // rrPtr is 1: grant req1 alone so it returns to 0
    bus.reqAddr[0] = 6'd3;
    bus.reqData[0] = 32'd100;
    bus.reqAddr[1] = 6'd9;
    bus.reqData[1] = 32'd200;
    bus.reqValid   = 2'b10;
    #1;
    check("r1_ready", 64'(bus.reqReady), 64'(2));
    tick();
    check("r1_wAddr", 64'(bus.wAddr), 64'(9));

    // both valid: 0,1,0,1
    bus.reqValid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready", 64'(bus.reqReady),
            (i % 2 == 0) ? 64'(1) : 64'(2));
      tick();
      check("rr_wEn", 64'(bus.wEn), 64'(1));
      check("rr_wAddr", 64'(bus.wAddr),
            (i % 2 == 0) ? 64'(3) : 64'(9));
      check("rr_wData", 64'($unsigned(bus.wData)),
            (i % 2 == 0) ? 64'(100) : 64'(200));
    end

    // illegal addresses 0 and 40
    bus.reqAddr[0] = 6'd0;
    bus.reqAddr[1] = 6'd40;
    #1;
    check("ill0_ready", 64'(bus.reqReady), 64'(1));
    tick();
    check("ill0_wEn", 64'(bus.wEn), 64'(0));
    check("ill1_ready", 64'(bus.reqReady), 64'(2));
    tick();
    check("ill1_wEn", 64'(bus.wEn), 64'(0));
    bus.reqValid = 2'b00;
`ifdef REGFILE_ARB_DROP_COUNT_EN
    check("drop_cnt", 64'(dropCount), 64'(2));
`endif

    // clearReq with req1 waiting
    bus.reqAddr[1] = 6'd7;
    bus.reqData[1] = 32'd55;
    bus.reqValid   = 2'b10;
    clearReq       = 1'b1;
    #1;
    check("clr_no_grant", 64'(bus.reqReady), 64'(0));
    check("clr_busy_pre", 64'(clearBusy), 64'(0));
    tick();
    clearReq = 1'b0;
    check("clr_wEn0", 64'(bus.wEn), 64'(0));
    check("clr_busy", 64'(clearBusy), 64'(1));
    check("clr_ready0", 64'(bus.reqReady), 64'(0));
`ifdef REGFILE_ARB_DROP_COUNT_EN
    check("drop_cnt_clr", 64'(dropCount), 64'(0));
`endif
    for (int i = 1; i <= 31; i++) begin
      tick();
      check("clr_wEn", 64'(bus.wEn), 64'(1));
      check("clr_wAddr", 64'(bus.wAddr), 64'(i));
      if (i < 31) begin
        check("clr_ready", 64'(bus.reqReady), 64'(0));
      end else begin
        check("clr_busy_end", 64'(clearBusy), 64'(0));
        check("clr_ready_end", 64'(bus.reqReady), 64'(2));
      end
    end
    tick();
    bus.reqValid = 2'b00;
    check("post_clr_wEn", 64'(bus.wEn), 64'(1));
    check("post_clr_wAddr", 64'(bus.wAddr), 64'(7));
    check("post_clr_wData", 64'($unsigned(bus.wData)), 64'(55));

    // reset while the pass is at clearPtr 10
    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
    end
    check("mid_wAddr9", 64'(bus.wAddr), 64'(9));
    #2;
    resetN = 1'b0;
    #1;
    check("mid_rst_wEn", 64'(bus.wEn), 64'(0));
    check("mid_rst_wAddr", 64'(bus.wAddr), 64'(0));
    check("mid_rst_busy", 64'(clearBusy), 64'(1));
    @(negedge clk);
    resetN = 1'b1;
    tick();
    check("restart_wEn", 64'(bus.wEn), 64'(1));
    check("restart_wAddr", 64'(bus.wAddr), 64'(1));
    tick();
    check("restart_wAddr2", 64'(bus.wAddr), 64'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single synchronous write port of the register file and shares it between NRequesters writeback sources, such as the ALU and the load unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- After reset, and on request, it sequences a clear pass that zeroes registers 1..NRegisters-1, because the register file contents have no reset.
- Sits between the writeback sources and the register file write port (wEn/wAddr/wData).

Parameters:
- NRequesters, 2, number of write sources (>=2)
- RegisterWidth, 32, data width
- NRegisters, 32, register count including hardwired x0; AddrWidth = $clog2(NRegisters)

Ports:
- clk  input  1  clock
- resetN  input  1  asynchronous active-low reset
- clearReq  input  1  one-cycle pulse; start a clear pass
- clearBusy  output  1  high while a clear pass is running
- reqValid  input  [NRequesters]  requester i has a write pending
- reqReady  output  [NRequesters]  requester i is granted this cycle
- reqAddr  input  [NRequesters][AddrWidth]  destination register
- reqData  input  [NRequesters][RegisterWidth] signed  write data
- wEn  output  1  to register file write enable
- wAddr  output  AddrWidth  to register file write address
- wData  output  RegisterWidth signed  to register file write data

Behaviour:
- Reset: resetN low asynchronously forces:
  - state=CLEAR, clearPtr=1, rrPtr=0
  - wEn=0, wAddr=0, wData=0, reqReady=0, clearBusy=1
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each clk edge registers wEn=1, wAddr=clearPtr, wData=0, then clearPtr++.
  - The edge that issues clearPtr==NRegisters-1 moves the FSM to RUN.
  - A pass therefore takes NRegisters-1 cycles.
  - reqReady is all-0 throughout.
- RUN:
  - reqReady is combinational: at most one bit high, and only for the requester that wins arbitration among asserted reqValid.
  - A transfer completes when reqValid[i] && reqReady[i] at a clk edge.
  - Latency 1: on that edge, wEn=1, wAddr=reqAddr[i], wData=reqData[i]. wEn is 0 on edges with no transfer.
- Round-robin:
  - rrPtr names the highest-priority requester; search order is rrPtr, rrPtr+1, ... mod NRequesters.
  - After a grant to i, rrPtr=(i+1) mod NRequesters.
  - rrPtr holds when there is no grant.
- Illegal address: a transfer to reqAddr==0 or reqAddr>=NRegisters is accepted (handshake completes) but dropped, with wEn=0 on that edge.
- clearReq in RUN: the next edge enters CLEAR with clearPtr=1.
  - No grant is issued in the cycle clearReq is high.
  - A write already registered on wEn/wAddr/wData completes normally.
- clearReq in CLEAR: ignored; the pass is not restarted.
- Requester behaviour: may hold reqValid indefinitely; must hold reqAddr/reqData stable while valid and not ready.
- Reset mid-pass or mid-write: wEn drops asynchronously; a new full clear pass follows release.
- Single-beat handshake only; no buffering inside the block.

Optional Feature:
- Macro: REGFILE_ARB_DROP_COUNT_EN.
- Defined:
  - Adds output dropCount [15:0].
  - It increments, saturating at 16'hFFFF, on each accepted transfer whose address is dropped.
  - It resets to 0 on resetN low and on entry to CLEAR.
- Undefined: port and counter are absent; drop behaviour is otherwise identical.

Decomposition:
- Package regfile_arb_pkg holds:
  - typedef enum logic {CLEAR, RUN} arb_state_t
  - function addr_width(n) returning $clog2(n)
- Sub-module rr_arbiter(NRequesters):
  - Inputs: request vector, rrPtr, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; rrPtr update stays in the parent.

Test Plan:
- Reset release, NRegisters=32: wEn=1 with wAddr=1..31 and wData=0 on 31 consecutive edges; clearBusy falls after the addr-31 edge; reqReady stays 0 throughout the pass.
- Single requester in RUN (req0: addr 5, data -7): reqReady[0]=1 same cycle; next edge gives wEn=1, wAddr=5, wData=-7; following edge gives wEn=0.
- Both requesters valid continuously, rrPtr=0: grants alternate 0,1,0,1; wAddr sequence matches the respective requests; no starvation.
- Requests to addr 0 and addr 40 (NRegisters=32, AddrWidth=6): handshakes complete, wEn stays 0; with REGFILE_ARB_DROP_COUNT_EN, dropCount=2.
- clearReq while req1 is valid: no grant that cycle; the 31-cycle clear pass follows; req1 is granted the cycle after clearBusy falls.
- resetN low mid-pass at clearPtr=10: wEn=0 immediately; after release the pass restarts at wAddr=1.
